// File: rtl/payload_csum_pkg.sv
// Shared types and widths for the payload checksum scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package payload_csum_pkg;
    localparam int DATA_W    = 64;
    localparam int CSUM_W    = 16;
    localparam int KEEP_W    = 8;
    localparam int TMO_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_CSUM
    } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requesting channel at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller decides when the grant is taken.
// Ports: req (N_CH) + ptr (CH_W) in; one-hot gnt (N_CH) + gnt_idx (CH_W) out.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] gnt_idx
);
    logic          found;
    logic [CH_W:0] c;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        c       = '0;
        for (int off = 0; off < N_CH; off++) begin
            // one extra bit so ptr+off can exceed N_CH-1 before wrapping
            c = {1'b0, ptr} + (CH_W+1)'(off);
            if (c >= (CH_W+1)'(N_CH)) begin
                c = c - (CH_W+1)'(N_CH);
            end
            if (!found && req[c[CH_W-1:0]]) begin
                found               = 1'b1;
                gnt[c[CH_W-1:0]]    = 1'b1;
                gnt_idx             = c[CH_W-1:0];
            end
        end
    end
endmodule

// File: rtl/payload_csum_sched.sv
// Shares one payload checksum accumulator between N_CH streams, whole frames round-robin.
// Latency: last beat accepted at T -> acc_* at T+1, m_csum_valid at T+4; next frame no earlier than T+5.
// Backpressure: new grant only while the result slot is free; m_csum_* held until m_csum_ready.
// Ports: s_t* per-channel AXI-S style inputs / s_tready; acc_* to/from accumulator; m_csum_* tagged result.
// Optional: PAYLOAD_CSUM_TKEEP_EN adds s_tkeep and zeroes unkept bytes of each frame's last beat.
module payload_csum_sched
    import payload_csum_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int TMO_CYC = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   s_tdata,
    input  logic [N_CH-1:0]          s_tvalid,
    input  logic [N_CH-1:0]          s_tlast,
`ifdef PAYLOAD_CSUM_TKEEP_EN
    input  logic [N_CH*KEEP_W-1:0]   s_tkeep,
`endif
    output logic [N_CH-1:0]          s_tready,
    output logic [DATA_W-1:0]        acc_data,
    output logic                     acc_data_valid,
    output logic                     acc_last,
    input  logic [CSUM_W-1:0]        acc_crc,
    input  logic                     acc_crc_valid,
    output logic [CSUM_W-1:0]        m_csum,
    output logic [CH_W-1:0]          m_csum_ch,
    output logic                     m_csum_err,
    output logic                     m_csum_valid,
    input  logic                     m_csum_ready
);
    state_e                 state_q, state_d;
    logic [CH_W-1:0]        rr_q, rr_d, gnt_q, gnt_d, arb_idx, rr_next;
    logic [N_CH-1:0]        gnt_oh_q, gnt_oh_d, arb_gnt;
    logic [DATA_W-1:0]      acc_data_q, acc_data_d, beat_dat;
    logic                   acc_data_valid_q, acc_data_valid_d;
    logic                   acc_last_q, acc_last_d;
    logic [CSUM_W-1:0]      m_csum_q, m_csum_d;
    logic [CH_W-1:0]        m_csum_ch_q, m_csum_ch_d;
    logic                   m_csum_err_q, m_csum_err_d;
    logic                   m_csum_valid_q, m_csum_valid_d;
    logic [TMO_CNT_W-1:0]   tmo_q, tmo_d;
    logic                   slot_free, beat_acc;
    logic [DATA_W-1:0]      ch_dat [N_CH];

    rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
        .req     (s_tvalid),
        .ptr     (rr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_dat[i] = s_tdata[i*DATA_W +: DATA_W];
        end
    end

`ifdef PAYLOAD_CSUM_TKEEP_EN
    logic [KEEP_W-1:0] ch_keep [N_CH];

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_keep[i] = s_tkeep[i*KEEP_W +: KEEP_W];
        end
    end

    // only the final beat can be partial; earlier beats are always full words
    always_comb begin
        beat_dat = ch_dat[gnt_q];
        if (s_tlast[gnt_q]) begin
            for (int k = 0; k < KEEP_W; k++) begin
                if (!ch_keep[gnt_q][k]) begin
                    beat_dat[k*8 +: 8] = 8'h00;
                end
            end
        end
    end
`else
    assign beat_dat = ch_dat[gnt_q];
`endif

    // ready comes straight from state so it drops the moment STREAM is left
    assign s_tready  = (state_q == STREAM) ? gnt_oh_q : '0;
    assign beat_acc  = (state_q == STREAM) && s_tvalid[gnt_q];
    assign slot_free = !m_csum_valid_q || m_csum_ready;
    assign rr_next   = (gnt_q == CH_W'(N_CH - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d          = state_q;
        rr_d             = rr_q;
        gnt_d            = gnt_q;
        gnt_oh_d         = gnt_oh_q;
        acc_data_d       = acc_data_q;
        acc_data_valid_d = 1'b0;
        acc_last_d       = 1'b0;
        m_csum_d         = m_csum_q;
        m_csum_ch_d      = m_csum_ch_q;
        m_csum_err_d     = m_csum_err_q;
        m_csum_valid_d   = m_csum_valid_q && !m_csum_ready;
        tmo_d            = tmo_q;

        unique case (state_q)
            IDLE: begin
                if ((|s_tvalid) && slot_free) begin
                    gnt_d    = arb_idx;
                    gnt_oh_d = arb_gnt;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (beat_acc) begin
                    acc_data_d       = beat_dat;
                    acc_data_valid_d = 1'b1;
                    acc_last_d       = s_tlast[gnt_q];
                    if (s_tlast[gnt_q]) begin
                        tmo_d   = '0;
                        state_d = WAIT_CSUM;
                    end
                end
            end
            WAIT_CSUM: begin
                // acc_data_valid/acc_last stay low here: covers the accumulator's
                // clear cycle and guarantees a falling edge on acc_last
                if (acc_crc_valid) begin
                    m_csum_d       = acc_crc;
                    m_csum_ch_d    = gnt_q;
                    m_csum_err_d   = 1'b0;
                    m_csum_valid_d = 1'b1;
                    rr_d           = rr_next;
                    tmo_d          = '0;
                    state_d        = IDLE;
                end else if (tmo_q == TMO_CNT_W'(TMO_CYC - 1)) begin
                    m_csum_d       = '0;
                    m_csum_ch_d    = gnt_q;
                    m_csum_err_d   = 1'b1;
                    m_csum_valid_d = 1'b1;
                    rr_d           = rr_next;
                    tmo_d          = '0;
                    state_d        = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            rr_q             <= '0;
            gnt_q            <= '0;
            gnt_oh_q         <= '0;
            acc_data_q       <= '0;
            acc_data_valid_q <= 1'b0;
            acc_last_q       <= 1'b0;
            m_csum_q         <= '0;
            m_csum_ch_q      <= '0;
            m_csum_err_q     <= 1'b0;
            m_csum_valid_q   <= 1'b0;
            tmo_q            <= '0;
        end else begin
            state_q          <= state_d;
            rr_q             <= rr_d;
            gnt_q            <= gnt_d;
            gnt_oh_q         <= gnt_oh_d;
            acc_data_q       <= acc_data_d;
            acc_data_valid_q <= acc_data_valid_d;
            acc_last_q       <= acc_last_d;
            m_csum_q         <= m_csum_d;
            m_csum_ch_q      <= m_csum_ch_d;
            m_csum_err_q     <= m_csum_err_d;
            m_csum_valid_q   <= m_csum_valid_d;
            tmo_q            <= tmo_d;
        end
    end

    assign acc_data       = acc_data_q;
    assign acc_data_valid = acc_data_valid_q;
    assign acc_last       = acc_last_q;
    assign m_csum         = m_csum_q;
    assign m_csum_ch      = m_csum_ch_q;
    assign m_csum_err     = m_csum_err_q;
    assign m_csum_valid   = m_csum_valid_q;
endmodule
